front_pipe_regs: RTL and testbench

// - PC register, IF/ID register and ID/EX register of the 5-stage RV32I core.
// - Consumes StallF/StallD/FlushD/FlushE/PCSrcE from the hazard unit.
// - Produces the E-stage operands and register indices (Rs1E/Rs2E/RdE, ResultSrcE) that the hazard unit compares.
// - Keeps saturating stall/flush event counters for performance debug.

---
 rtl/front_pipe_regs.sv | 143 ++++++++++++++
 tb/tb_front_pipe_regs.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/front_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module      : front_pipe_regs
// Description : PC, IF/ID and ID/EX pipeline registers of a 5-stage RV32I core,
//               with saturating stall/flush event counters for debug.
// Revision    : 1.0 - initial release
// ============================================================================
module front_pipe_regs #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP      = 32'h0000_0013,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [31:0]      InstrF,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [9:0]       CtrlD,
  output logic [XLEN-1:0]  PCF,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic [9:0]       CtrlE,
  output logic             ValidD,
  output logic             ValidE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] c_cntMax = '1;

  logic [XLEN-1:0] w_pcPlus4F;
  logic [4:0]      w_rs1D;
  logic [4:0]      w_rs2D;
  logic [4:0]      w_rdD;
  logic            w_flushEvt;

  assign w_pcPlus4F = PCF + XLEN'(4);
  assign w_rs1D     = InstrD[19:15];
  assign w_rs2D     = InstrD[24:20];
  assign w_rdD      = InstrD[11:7];
  assign w_flushEvt = FlushD | FlushE;

  // A redirect from E must win over a fetch stall, or a taken branch would be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else if (PCSrcE) begin
      PCF <= PCTargetE;
    end else if (!StallF) begin
      PCF <= w_pcPlus4F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= w_pcPlus4F;
      ValidD   <= 1'b1;
    end
  end

  // Zeroing CtrlE on a bubble clears ResultSrcE, so the bubble never looks like a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      CtrlE    <= '0;
      ValidE   <= 1'b0;
    end else if (FlushE) begin
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      CtrlE    <= '0;
      ValidE   <= 1'b0;
    end else begin
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= w_rs1D;
      Rs2E     <= w_rs2D;
      RdE      <= w_rdD;
      CtrlE    <= CtrlD;
      ValidE   <= ValidD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != c_cntMax)) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
      if (w_flushEvt && (FlushCnt != c_cntMax)) begin
        FlushCnt <= FlushCnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_front_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_front_pipe_regs
// Description : Scoreboard bench for front_pipe_regs; directed vectors queue
//               hand-computed expectations, a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_front_pipe_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0, InstrF = '0, RD1D = 32'h1111_1111, RD2D = 32'h2222_2222;
  logic [31:0] ImmExtD = 32'h0000_0005;
  logic [9:0]  CtrlD = '0;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [9:0]  CtrlE;
  logic        ValidD, ValidE;
  logic [15:0] StallCnt, FlushCnt;

  front_pipe_regs dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .CtrlD(CtrlD),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .CtrlE(CtrlE),
    .ValidD(ValidD), .ValidE(ValidE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] pcF, instrD, pcD, pcPlus4D;
    logic        validD, validE;
    logic [9:0]  ctrlE;
    logic [4:0]  rdE;
    logic [15:0] stallCnt, flushCnt;
  } exp_t;

  exp_t q[$];
  event chkNow;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] c_nop = 32'h0000_0013;
  localparam logic [31:0] c_i0  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] c_i1  = 32'h0020_8133; // add  x2,x1,x2
  localparam logic [31:0] c_i2  = 32'h0000_A183; // lw   x3,0(x1)
  localparam logic [31:0] c_i3  = 32'h0031_8233; // add  x4,x3,x3
  localparam logic [31:0] c_i4  = 32'h0040_0293; // addi x5,x0,4
  localparam logic [9:0]  c_alu = 10'h2A5;
  localparam logic [9:0]  c_ld  = 10'h283;

  function automatic exp_t mk(int tag, logic [31:0] pcF, logic [31:0] instrD,
                              logic [31:0] pcD, logic [31:0] pcPlus4D, logic vD, logic vE,
                              logic [9:0] ctrlE, logic [4:0] rdE, logic [15:0] sc, logic [15:0] fc);
    exp_t e;
    e.tag = tag; e.pcF = pcF; e.instrD = instrD; e.pcD = pcD; e.pcPlus4D = pcPlus4D;
    e.validD = vD; e.validE = vE; e.ctrlE = ctrlE; e.rdE = rdE;
    e.stallCnt = sc; e.flushCnt = fc;
    return e;
  endfunction

  task automatic cmp(input int tag, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL tag=%0d %s got %h expected %h", tag, nm, act, req);
    end
  endtask

  // One clock of stimulus; expectation describes state after the following posedge.
  task automatic cyc(input logic sF, input logic sD, input logic fD, input logic fE,
                     input logic pcs, input logic [31:0] tgt, input logic [31:0] instr,
                     input logic [9:0] ctrl, input bit chk, input exp_t e);
    @(negedge clk);
    rst = 1'b0; StallF = sF; StallD = sD; FlushD = fD; FlushE = fE; PCSrcE = pcs;
    PCTargetE = tgt; InstrF = instr; CtrlD = ctrl;
    if (chk) q.push_back(e);
  endtask

  task automatic rstChk(input exp_t e);
    @(negedge clk);
    rst = 1'b1;
    q.push_back(e);
    -> chkNow;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or chkNow);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.tag, "PCF",      PCF,             e.pcF);
        cmp(e.tag, "InstrD",   InstrD,          e.instrD);
        cmp(e.tag, "PCD",      PCD,             e.pcD);
        cmp(e.tag, "PCPlus4D", PCPlus4D,        e.pcPlus4D);
        cmp(e.tag, "ValidD",   32'(ValidD),     32'(e.validD));
        cmp(e.tag, "ValidE",   32'(ValidE),     32'(e.validE));
        cmp(e.tag, "CtrlE",    32'(CtrlE),      32'(e.ctrlE));
        cmp(e.tag, "RdE",      32'(RdE),        32'(e.rdE));
        cmp(e.tag, "StallCnt", 32'(StallCnt),   32'(e.stallCnt));
        cmp(e.tag, "FlushCnt", 32'(FlushCnt),   32'(e.flushCnt));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //          tag pcF           instrD  pcD           pcPlus4D      vD vE ctrlE  rdE sc      fc
    rstChk(mk(  0, 32'h0,        c_nop,  32'h0,        32'h0,        0, 0, 10'h0, 0, 16'd0,  16'd0));
    // free run
    cyc(0,0,0,0,0, 0, c_i0, c_alu, 1, mk(1, 32'h4, c_i0, 32'h0, 32'h4, 1, 0, c_alu, 0, 0, 0));
    cyc(0,0,0,0,0, 0, c_i1, c_alu, 1, mk(2, 32'h8, c_i1, 32'h4, 32'h8, 1, 1, c_alu, 1, 0, 0));
    cyc(0,0,0,0,0, 0, c_i2, c_alu, 1, mk(3, 32'hC, c_i2, 32'h8, 32'hC, 1, 1, c_alu, 2, 0, 0));
    cyc(0,0,0,0,0, 0, c_i3, c_ld,  1, mk(4, 32'h10, c_i3, 32'hC, 32'h10, 1, 1, c_ld, 3, 0, 0));
    // load-use stall at PCF=0x10
    cyc(1,1,0,1,0, 0, c_i4, c_alu, 1, mk(5, 32'h10, c_i3, 32'hC, 32'h10, 1, 0, 10'h0, 0, 1, 1));
    cyc(0,0,0,0,0, 0, c_i4, c_alu, 1, mk(6, 32'h14, c_i4, 32'h10, 32'h14, 1, 1, c_alu, 4, 1, 1));
    // taken branch to 0x40: both flushes in one cycle count once
    cyc(0,0,1,1,1, 32'h40, 32'hDEADBEEF, c_alu, 1, mk(7, 32'h40, c_nop, 0, 0, 0, 0, 10'h0, 0, 1, 2));
    // PCSrcE beats StallF, FlushD beats StallD
    cyc(1,1,1,0,1, 32'h80, 32'hDEADBEEF, c_alu, 1, mk(8, 32'h80, c_nop, 0, 0, 0, 0, c_alu, 0, 2, 3));
    cyc(0,0,0,0,0, 0, c_i0, c_alu, 1, mk(9, 32'h84, c_i0, 32'h80, 32'h84, 1, 0, c_alu, 0, 2, 3));
    // PC wraps modulo 2^32
    cyc(0,0,0,0,1, 32'hFFFF_FFFC, c_i1, c_alu, 1,
        mk(10, 32'hFFFF_FFFC, c_i1, 32'h84, 32'h88, 1, 1, c_alu, 1, 2, 3));
    cyc(0,0,0,0,0, 0, c_i2, c_alu, 1,
        mk(11, 32'h0, c_i2, 32'hFFFF_FFFC, 32'h0, 1, 1, c_alu, 2, 2, 3));
    // asynchronous reset mid-run, checked before any clock edge
    rstChk(mk( 12, 32'h0, c_nop, 0, 0, 0, 0, 10'h0, 0, 0, 0));
    cyc(0,0,0,0,0, 0, c_i1, c_alu, 1, mk(13, 32'h4, c_i1, 32'h0, 32'h4, 1, 0, c_alu, 0, 0, 0));
    // stall counter saturation over 2^16+5 cycles
    for (int i = 0; i < 65540; i++) cyc(1,1,0,0,0, 0, c_i2, c_alu, 0, none);
    cyc(1,1,0,0,0, 0, c_i2, c_alu, 1, mk(14, 32'h4, c_i1, 32'h0, 32'h4, 1, 1, c_alu, 2, 16'hFFFF, 0));
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
